// File: rtl/pipe_ctrl_pkg.sv
// Shared stage indices, controller FSM encoding and default depth for the pipeline stall/flush controller.
// Pure declarations: no logic, no latency, no flow control.
package pipe_ctrl_pkg;

  localparam int DEF_NUM_STAGES = 6;

  localparam int STG_FETCH  = 0;
  localparam int STG_DECODE = 1;
  localparam int STG_ISSUE  = 2;
  localparam int STG_EXEC   = 3;
  localparam int STG_MEM    = 4;
  localparam int STG_WB     = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Request/response bundle between the pipeline stages (master) and the stall controller (slave).
// Perf-counter select/readback signals exist only when STALL_PERF_CNT_EN is defined.
interface pipeline_stall_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int CNT_W      = 16
);
  localparam int SEL_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic [NUM_STAGES-1:0] stall_req_i;
  logic [NUM_STAGES-1:0] flush_req_i;
  logic                  wdog_clr_i;
  logic [NUM_STAGES-1:0] stall_o;
  logic [NUM_STAGES-1:0] bubble_o;
  logic [NUM_STAGES-1:0] flush_o;
  logic                  stall_active_o;
  logic                  watchdog_o;
  logic [CNT_W-1:0]      stall_cycles_o;
`ifdef STALL_PERF_CNT_EN
  logic [SEL_W-1:0]      perf_sel_i;
  logic [CNT_W-1:0]      perf_cnt_o;

  modport master (
    output stall_req_i, flush_req_i, wdog_clr_i, perf_sel_i,
    input  stall_o, bubble_o, flush_o, stall_active_o, watchdog_o, stall_cycles_o, perf_cnt_o
  );
  modport slave (
    input  stall_req_i, flush_req_i, wdog_clr_i, perf_sel_i,
    output stall_o, bubble_o, flush_o, stall_active_o, watchdog_o, stall_cycles_o, perf_cnt_o
  );
`else
  modport master (
    output stall_req_i, flush_req_i, wdog_clr_i,
    input  stall_o, bubble_o, flush_o, stall_active_o, watchdog_o, stall_cycles_o
  );
  modport slave (
    input  stall_req_i, flush_req_i, wdog_clr_i,
    output stall_o, bubble_o, flush_o, stall_active_o, watchdog_o, stall_cycles_o
  );
`endif

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment), updated on the falling edge.
// Count visible one negedge after i_inc; never wraps, holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: requests sampled on negedge, all outputs registered there (one half-cycle to next posedge).
// No backpressure of its own; STALL_PERF_CNT_EN adds per-stage stall counters with a registered select/readback.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES   = DEF_NUM_STAGES,
  parameter int FLUSH_CYCLES = 2,
  parameter int WDOG_LIMIT   = 255,
  parameter int CNT_W        = 16
) (
  input logic                  clock_i,
  input logic                  reset_i,
  pipeline_stall_ctrl_if.slave bus
);

  localparam int HOLD_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WD_W   = $clog2(WDOG_LIMIT + 1);

  ctrl_state_e           r_state, w_state_nxt;
  logic [HOLD_W-1:0]     r_hold, w_hold_nxt;
  logic [NUM_STAGES-1:0] r_fmask, w_fmask_nxt;
  logic [NUM_STAGES-1:0] r_stall, w_stall_nxt;
  logic [NUM_STAGES-1:0] r_bubble, w_bubble_nxt;
  logic [NUM_STAGES-1:0] w_stall_mask, w_flush_new;
  logic                  w_acc_s, w_acc_f;
  logic                  r_active, w_active_nxt;
  logic                  r_wdog, w_wdog_set;
  logic [WD_W-1:0]       w_wd_cnt;
  logic [CNT_W-1:0]      w_cyc_cnt;

  // Stall covers every stage at or below the oldest staller; flush covers stages strictly below the oldest flusher.
  always_comb begin
    w_acc_s      = 1'b0;
    w_acc_f      = 1'b0;
    w_stall_mask = '0;
    w_flush_new  = '0;
    w_bubble_nxt = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      w_acc_s         = w_acc_s | bus.stall_req_i[i];
      w_stall_mask[i] = w_acc_s;
      w_flush_new[i]  = w_acc_f;
      w_acc_f         = w_acc_f | bus.flush_req_i[i];
    end
    for (int i = 1; i < NUM_STAGES; i++) begin
      w_bubble_nxt[i] = w_stall_mask[i-1] & ~w_stall_mask[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_fmask_nxt = r_fmask;
    if (|bus.flush_req_i) begin
      w_state_nxt = FLUSH;
      w_fmask_nxt = ((r_state == FLUSH) ? r_fmask : '0) | w_flush_new;
      w_hold_nxt  = HOLD_W'(FLUSH_CYCLES - 1);
    end else begin
      case (r_state)
        RUN:     if (|bus.stall_req_i) w_state_nxt = STALL;
        STALL:   if (!(|bus.stall_req_i)) w_state_nxt = RUN;
        FLUSH: begin
          if (r_hold != '0) begin
            w_hold_nxt = r_hold - HOLD_W'(1);
          end else begin
            w_fmask_nxt = '0;
            w_state_nxt = (|bus.stall_req_i) ? STALL : RUN;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
    w_stall_nxt  = w_stall_mask & ~w_fmask_nxt;
    w_active_nxt = |w_stall_nxt;
    w_wdog_set   = w_active_nxt && (int'(w_wd_cnt) >= WDOG_LIMIT - 1);
  end

  always_ff @(negedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state  <= RUN;
      r_hold   <= '0;
      r_fmask  <= '0;
      r_stall  <= '0;
      r_bubble <= '0;
      r_active <= 1'b0;
      r_wdog   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_hold   <= w_hold_nxt;
      r_fmask  <= w_fmask_nxt;
      r_stall  <= w_stall_nxt;
      r_bubble <= w_bubble_nxt;
      r_active <= w_active_nxt;
      if (bus.wdog_clr_i) begin
        r_wdog <= 1'b0;
      end else if (w_wdog_set) begin
        r_wdog <= 1'b1;
      end
    end
  end

  // Run length of the current continuous stall; any idle cycle or an explicit clear restarts it.
  sat_counter #(.W(WD_W)) u_wdog_cnt (
    .i_clk   (clock_i),
    .i_rst_n (reset_i),
    .i_inc   (w_active_nxt),
    .i_clr   (bus.wdog_clr_i | ~w_active_nxt),
    .o_cnt   (w_wd_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .i_clk   (clock_i),
    .i_rst_n (reset_i),
    .i_inc   (w_active_nxt),
    .i_clr   (1'b0),
    .o_cnt   (w_cyc_cnt)
  );

  assign bus.stall_o        = r_stall;
  assign bus.bubble_o       = r_bubble;
  assign bus.flush_o        = r_fmask;
  assign bus.stall_active_o = r_active;
  assign bus.watchdog_o     = r_wdog;
  assign bus.stall_cycles_o = w_cyc_cnt;

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] w_perf_cnt [NUM_STAGES];
  logic [CNT_W-1:0] w_perf_mux;
  logic [CNT_W-1:0] r_perf;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_perf
    sat_counter #(.W(CNT_W)) u_perf_cnt (
      .i_clk   (clock_i),
      .i_rst_n (reset_i),
      .i_inc   (bus.stall_req_i[k]),
      .i_clr   (1'b0),
      .o_cnt   (w_perf_cnt[k])
    );
  end

  always_comb begin
    w_perf_mux = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (int'(bus.perf_sel_i) == k) w_perf_mux = w_perf_cnt[k];
    end
  end

  always_ff @(negedge clock_i or negedge reset_i) begin
    if (!reset_i) r_perf <= '0;
    else          r_perf <= w_perf_mux;
  end

  assign bus.perf_cnt_o = r_perf;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized + directed bench for pipeline_stall_ctrl with a queue scoreboard and a rule-level reference model.
module tb_pipeline_stall_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int NS = 6;
  localparam int FC = 2;
  localparam int WL = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus ();

  pipeline_stall_ctrl #(
    .NUM_STAGES(NS), .FLUSH_CYCLES(FC), .WDOG_LIMIT(WL), .CNT_W(CW)
  ) dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [NS-1:0] stall;
    logic [NS-1:0] bubble;
    logic [NS-1:0] flush;
    logic          active;
    logic          wdog;
    logic [CW-1:0] cyc;
    logic [CW-1:0] perf;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  // Reference model: flush visible through step index m_fend, plain run-length and saturating counts.
  int            step_n = 0;
  int            m_fend = -10;
  logic [NS-1:0] m_fmask = '0;
  int            m_wrun = 0;
  bit            m_wdog = 1'b0;
  int            m_cyc = 0;
  int            m_pc[NS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_fend  = -10;
    m_fmask = '0;
    m_wrun  = 0;
    m_wdog  = 1'b0;
    m_cyc   = 0;
    for (int k = 0; k < NS; k++) m_pc[k] = 0;
  endtask

  task automatic apply(input logic [NS-1:0] st, input logic [NS-1:0] fl, input bit clr, input int sel);
    exp_t e;
    int ks;
    int kf;
    logic [NS-1:0] fnew;
    logic [NS-1:0] fout;
    logic [NS-1:0] sset;
    bus.stall_req_i = st;
    bus.flush_req_i = fl;
    bus.wdog_clr_i  = clr;
`ifdef STALL_PERF_CNT_EN
    bus.perf_sel_i  = sel[2:0];
`endif
    ks = -1;
    kf = -1;
    for (int i = 0; i < NS; i++) begin
      if (st[i]) ks = i;
      if (fl[i]) kf = i;
    end
    sset = '0;
    fnew = '0;
    for (int i = 0; i < NS; i++) begin
      if (i <= ks) sset[i] = 1'b1;
      if (i < kf)  fnew[i] = 1'b1;
    end
    if (kf >= 0) begin
      m_fmask = ((step_n - 1 <= m_fend) ? m_fmask : '0) | fnew;
      m_fend  = step_n + FC - 1;
    end
    fout     = (step_n <= m_fend) ? m_fmask : '0;
    e.flush  = fout;
    e.stall  = sset & ~fout;
    e.bubble = '0;
    if (ks >= 0 && ks < NS - 1) e.bubble[ks+1] = 1'b1;
    e.active = |e.stall;
    if (e.active && m_cyc < CMAX) m_cyc++;
    e.cyc = m_cyc[CW-1:0];
    if (clr) begin
      m_wdog = 1'b0;
      m_wrun = 0;
    end else if (e.active) begin
      m_wrun++;
      if (m_wrun >= WL) m_wdog = 1'b1;
    end else begin
      m_wrun = 0;
    end
    e.wdog = m_wdog;
    e.perf = (sel < NS) ? m_pc[sel][CW-1:0] : '0;
    for (int k = 0; k < NS; k++) if (st[k] && m_pc[k] < CMAX) m_pc[k]++;
    q.push_back(e);
    step_n++;
  endtask

  task automatic step(input logic [NS-1:0] st, input logic [NS-1:0] fl, input bit clr, input int sel);
    @(posedge clk);
    #1;
    apply(st, fl, clr, sel);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"},  32'(bus.stall_o), 32'd0);
    chk({tag, "_bubble"}, 32'(bus.bubble_o), 32'd0);
    chk({tag, "_flush"},  32'(bus.flush_o), 32'd0);
    chk({tag, "_active"}, 32'(bus.stall_active_o), 32'd0);
    chk({tag, "_wdog"},   32'(bus.watchdog_o), 32'd0);
    chk({tag, "_cycles"}, 32'(bus.stall_cycles_o), 32'd0);
`ifdef STALL_PERF_CNT_EN
    chk({tag, "_perf"},   32'(bus.perf_cnt_o), 32'd0);
`endif
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.stall_req_i = '0;
    bus.flush_req_i = '0;
    bus.wdog_clr_i  = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    #1;
    rst_n = 1'b1;
    apply('0, '0, 1'b0, 0);
  endtask

  // Monitor: the controller presents a registered result every cycle; compare at posedge, away from negedge updates.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        chk("stall_o",        32'(bus.stall_o),        32'(e.stall));
        chk("bubble_o",       32'(bus.bubble_o),       32'(e.bubble));
        chk("flush_o",        32'(bus.flush_o),        32'(e.flush));
        chk("stall_active_o", 32'(bus.stall_active_o), 32'(e.active));
        chk("watchdog_o",     32'(bus.watchdog_o),     32'(e.wdog));
        chk("stall_cycles_o", 32'(bus.stall_cycles_o), 32'(e.cyc));
`ifdef STALL_PERF_CNT_EN
        chk("perf_cnt_o",     32'(bus.perf_cnt_o),     32'(e.perf));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    bus.stall_req_i = '0;
    bus.flush_req_i = '0;
    bus.wdog_clr_i  = 1'b0;
`ifdef STALL_PERF_CNT_EN
    bus.perf_sel_i  = '0;
`endif
    model_reset();
    #2;
    check_all_zero("reset");
    #1;
    rst_n = 1'b1;

    repeat (3) step(6'b000100, '0, 1'b0, 2);
    repeat (2) step('0, '0, 1'b0, 2);

    step('0, 6'b010000, 1'b0, 0);
    repeat (3) step('0, '0, 1'b0, 0);

    step(6'b100000, 6'b001000, 1'b0, 5);
    repeat (3) step('0, '0, 1'b0, 5);

    repeat (6) step(6'b000010, '0, 1'b0, 1);
    step(6'b000010, '0, 1'b1, 1);
    repeat (2) step('0, '0, 1'b0, 1);

    step('0, 6'b010000, 1'b0, 0);
    reset_pulse();
    repeat (2) step('0, '0, 1'b0, 0);

    repeat (20) step(6'b000010, '0, 1'b0, 1);
    repeat (2) step('0, '0, 1'b0, 1);

    step('0, 6'b000001, 1'b0, 7);
    step(6'b001000, 6'b100000, 1'b0, 3);
    step('0, 6'b000100, 1'b0, 6);
    repeat (3) step('0, '0, 1'b0, 0);

    for (int n = 0; n < 400; n++) begin
      logic [NS-1:0] st;
      logic [NS-1:0] fl;
      st = ($urandom_range(0, 2) == 0) ? '0 : NS'($urandom);
      fl = ($urandom_range(0, 6) == 0) ? NS'($urandom) : '0;
      step(st, fl, ($urandom_range(0, 9) == 0), int'($urandom_range(0, 7)));
      if (n == 200) reset_pulse();
    end
    step('0, '0, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
